// File: rtl/fp_sqr_sched.sv
// Two-port round-robin scheduler for a multi-cycle square-root unit, one operation in flight.
// Define FP_SQR_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog (quiet-NaN response on expiry).
module fp_sqr_sched #(
   parameter int W       = 32,
   parameter int LAT_MIN = 3,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [W-1:0] req_op0,
   input  logic [W-1:0] req_op1,
   input  logic [2:0]   req_rm0,
   input  logic [2:0]   req_rm1,
   output logic [1:0]   rsp_valid,
   input  logic [1:0]   rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic [5:0]   rsp_flags,
   output logic [W-1:0] sqr_in,
   output logic [2:0]   sqr_round_m,
   output logic         sqr_act,
   input  logic [W-1:0] sqr_out,
   input  logic         sqr_done,
   input  logic         sqr_ov,
   input  logic         sqr_un,
   input  logic         sqr_inv,
   input  logic         sqr_inexact
);
   localparam int CMAX = (TIMEOUT > LAT_MIN) ? TIMEOUT : LAT_MIN;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state, nxt;
   logic [W-1:0]   op_r, rsp_data_r;
   logic [2:0]     rm_r;
   logic [4:0]     flg_r;
   logic [CW-1:0]  cnt;
   logic [1:0]     rdy;
   logic           last_gnt, g_r, gnt, take, done_ok, to_hit;

   always_comb begin
      nxt     = state;
      rdy     = 2'b00;
      gnt     = 1'b0;
      take    = 1'b0;
      done_ok = 1'b0;
      to_hit  = 1'b0;
      case (state)
         IDLE: if (|req_valid) begin
            // on a tie the port that was not served last wins
            gnt      = (&req_valid) ? ~last_gnt : req_valid[1];
            rdy[gnt] = 1'b1;
            take     = 1'b1;
            nxt      = ISSUE;
         end
         ISSUE: nxt = WAIT;
         WAIT: begin
            // a done seen this early may belong to the previous operation
            done_ok = sqr_done && (cnt >= CW'(LAT_MIN));
`ifdef FP_SQR_SCHED_TIMEOUT_EN
            to_hit  = !done_ok && (cnt == CW'(TIMEOUT));
`endif
            if (done_ok || to_hit) nxt = RESP;
         end
         RESP: if (rsp_ready[g_r]) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

`ifdef FP_SQR_SCHED_TIMEOUT_EN
   localparam logic [W-1:0] FP_NANQ = W'(32'h7FC0_0000);
   logic to_r;

   always_ff @(posedge clk) begin
      if (!rst)         to_r <= 1'b0;
      else if (done_ok) to_r <= 1'b0;
      else if (to_hit)  to_r <= 1'b1;
   end
   assign rsp_flags = {to_r, flg_r};
`else
   assign rsp_flags = {1'b0, flg_r};
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_gnt   <= 1'b1;
         g_r        <= 1'b0;
         cnt        <= '0;
         op_r       <= '0;
         rm_r       <= '0;
         rsp_data_r <= '0;
         flg_r      <= '0;
      end else begin
         if (take) begin
            op_r     <= gnt ? req_op1 : req_op0;
            rm_r     <= gnt ? req_rm1 : req_rm0;
            g_r      <= gnt;
            last_gnt <= gnt;
         end
         if (state == ISSUE) cnt <= '0;
         else if (state == WAIT) begin
`ifdef FP_SQR_SCHED_TIMEOUT_EN
            if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
`else
            // without the watchdog the count only gates done, so it stops at LAT_MIN
            if (cnt < CW'(LAT_MIN)) cnt <= cnt + 1'b1;
`endif
         end
         if (done_ok) begin
            rsp_data_r <= sqr_out;
            flg_r      <= {sqr_inv, sqr_ov, sqr_un, sqr_inexact, 1'b0};
         end
`ifdef FP_SQR_SCHED_TIMEOUT_EN
         else if (to_hit) begin
            rsp_data_r <= FP_NANQ;
            flg_r      <= 5'b10000;
         end
`endif
      end
   end

   assign req_ready   = rst ? rdy : 2'b00;
   assign rsp_valid   = (rst && state == RESP) ? (g_r ? 2'b10 : 2'b01) : 2'b00;
   assign sqr_act     = rst && (state == ISSUE || state == WAIT);
   assign sqr_in      = op_r;
   assign sqr_round_m = rm_r;
   assign rsp_data    = rsp_data_r;

endmodule

// File: doc/fp_sqr_sched.md
FP_SQR_SCHED -- requirements
Module: fp_sqr_sched

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the operand/result width.
REQ-002 The block SHALL have parameter LAT_MIN, default 3, meaning the minimum cycles after issue before sqr_done is trusted.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning the watchdog limit in cycles counted in WAIT.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have ports req_valid[1:0], input, 2, per-requester request valid.
REQ-007 The block SHALL have ports req_ready[1:0], output, 2, per-requester request accept.
REQ-008 The block SHALL have ports req_op0/req_op1, input, W each, operand from requester 0/1.
REQ-009 The block SHALL have ports req_rm0/req_rm1, input, 3 each, rounding mode from requester 0/1.
REQ-010 The block SHALL have ports rsp_valid[1:0], output, 2, and rsp_ready[1:0], input, 2, the per-requester response handshake.
REQ-011 The block SHALL have ports rsp_data, output, W, and rsp_flags, output, 6, packed as {timeout,inv,ov,un,inexact,0}.
REQ-012 The block SHALL have ports sqr_in, output, W; sqr_round_m, output, 3; and sqr_act, output, 1, driving the square-root unit.
REQ-013 The block SHALL have ports sqr_out, input, W; sqr_done, input, 1; and sqr_ov/sqr_un/sqr_inv/sqr_inexact, input, 1 each, from the square-root unit.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP, and SHALL keep at most one operation in flight.
REQ-015 In IDLE with any req_valid high, the block SHALL grant by round-robin: the port other than last_gnt wins a tie, and a sole requester always wins.
REQ-016 req_ready[g] SHALL be high only in the IDLE cycle that grants port g, and the transfer SHALL occur on req_valid[g] & req_ready[g].
REQ-017 On grant, the block SHALL register the operand and rounding mode into op_r/rm_r, record g, update last_gnt and enter ISSUE.
REQ-018 sqr_in and sqr_round_m SHALL equal op_r/rm_r, held stable from ISSUE through the end of WAIT; the unit's rounding stage is combinational on round_m.
REQ-019 sqr_act SHALL be high in ISSUE and WAIT and low otherwise.
REQ-020 ISSUE SHALL last exactly one cycle, clear wait counter cnt to 0 and advance to WAIT.
REQ-021 In WAIT, cnt SHALL increment each cycle and saturate at TIMEOUT.
REQ-022 In WAIT, sqr_done SHALL be ignored while cnt < LAT_MIN, because done can be stale from the previous operation.
REQ-023 In WAIT with cnt >= LAT_MIN and sqr_done high, the block SHALL capture sqr_out and the flags into rsp registers (timeout=0) and enter RESP.
REQ-024 In RESP, rsp_valid[g] SHALL be high and the other rsp_valid bit low, with rsp_data/rsp_flags stable until rsp_ready[g]; the handshake cycle SHALL return the FSM to IDLE.
REQ-025 A new grant SHALL NOT occur in the same cycle as the RESP handshake; the earliest new grant is the following cycle.
REQ-026 rsp_ready on the non-granted port SHALL be ignored.
REQ-027 Back-to-back throughput for one requester SHALL be 1 operation per (LAT_MIN + 4) cycles or slower.

Reset
REQ-028 When rst is low at a rising clk edge, the FSM SHALL go to IDLE, last_gnt to 1 (so port 0 wins the first tie), cnt to 0, and op_r, rm_r, rsp_data and rsp_flags to 0.
REQ-029 During and after reset, req_ready, rsp_valid and sqr_act SHALL be 0.
REQ-030 A reset in ISSUE, WAIT or RESP SHALL discard the in-flight operation, and no response SHALL be produced for it.

Configuration
REQ-031 Macro FP_SQR_SCHED_TIMEOUT_EN, when defined, SHALL enable the watchdog: in WAIT with cnt == TIMEOUT and no accepted done, the block enters RESP with rsp_data = FP_NANQ and rsp_flags = {1,1,0,0,0,0}.
REQ-032 With FP_SQR_SCHED_TIMEOUT_EN undefined, the block SHALL wait indefinitely in WAIT, omit the saturation logic, and tie rsp_flags[5] to 0.

Verification
REQ-033 The bench SHALL cover: port0 op 0x40800000 (4.0), rm=RNe -> rsp_valid[0] with rsp_data 0x40000000 and inv=0.
REQ-034 The bench SHALL cover: both ports valid after reset, port0 op 0x41100000 and port1 op 0x40800000 -> port0 served first (0x40400000), then port1 (0x40000000).
REQ-035 The bench SHALL cover: port1 op 0xBF800000 (-1.0) -> rsp_data FP_NANQ with inv=1 returned on port1 only.
REQ-036 The bench SHALL cover: sqr_done forced high during ISSUE and the first LAT_MIN-1 WAIT cycles -> no capture before cnt == LAT_MIN.
REQ-037 The bench SHALL cover: with the macro defined and sqr_done held 0 -> response after 64 WAIT cycles with rsp_flags 6'b110000; without the macro, no response after 1000 cycles.
REQ-038 The bench SHALL cover: rst low for 1 cycle mid-WAIT -> all outputs 0 the next cycle, no response, and the next tie is granted to port 0.
